// File: rtl/instruction_memory.sv
// Word-organised synchronous instruction memory serving the fetch read port,
// with a streaming load port used to write a program while the core is held off.
module instruction_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     i_inst_rd_enable,
    input  logic [31:0]                    i_inst_addr,
    output logic [31:0]                    o_inst_data,
    output logic                           o_fetch_fault,
    output logic                           o_busy,
    input  logic                           i_load_start,
    input  logic [31:0]                    i_load_addr,
    input  logic                           i_load_valid,
    input  logic [31:0]                    i_load_data,
    input  logic                           i_load_last,
    output logic                           o_load_ready,
    output logic [$clog2(DEPTH_WORDS):0]   o_load_count,
    output logic                           o_load_overflow
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CW    = AW + 1;
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic {RUN, LOAD} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] wr_ptr;
    logic [31:0]   load_off;
    logic [31:0]   fetch_off;
    logic [AW-1:0] start_ptr;
    logic [AW-1:0] rd_word;
    logic          load_accept;
    logic          fetch_ok;
    logic [31:0]   lane_mask;
    logic          unused_bits;

    assign load_off    = i_load_addr - BASE_ADDR;
    assign start_ptr   = load_off[AW+1:2];
    assign fetch_off   = i_inst_addr - BASE_ADDR;
    assign rd_word     = fetch_off[AW+1:2];
    assign load_accept = o_load_ready && i_load_valid;
    assign fetch_ok    = (i_inst_addr[1:0] == 2'b00)
                      && ({1'b0, i_inst_addr} >= 33'(BASE_ADDR))
                      && ({1'b0, i_inst_addr} < LIMIT);
    assign unused_bits = ^{load_off[31:AW+2], load_off[1:0],
                           fetch_off[31:AW+2], fetch_off[1:0]};

    // Disabled byte lanes read back as zero.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{i_inst_rd_enable[i]}};
        end
    end

    // Load-session FSM; busy/ready are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            wr_ptr          <= '0;
            o_load_count    <= '0;
            o_load_overflow <= 1'b0;
            o_busy          <= 1'b0;
            o_load_ready    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (i_load_start) begin
                        state           <= LOAD;
                        wr_ptr          <= start_ptr;
                        o_load_count    <= '0;
                        o_load_overflow <= 1'b0;
                        o_busy          <= 1'b1;
                        o_load_ready    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (wr_ptr == AW'(DEPTH_WORDS - 1)) begin
                            o_load_overflow <= 1'b1;
                        end
                        if (o_load_count != {CW{1'b1}}) begin
                            o_load_count <= o_load_count + CW'(1);
                        end
                        if (i_load_last) begin
                            state        <= RUN;
                            o_busy       <= 1'b0;
                            o_load_ready <= 1'b0;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Storage array is deliberately unreset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem[wr_ptr] <= i_load_data;
        end
    end

    // Fetch response holds its value while fetch is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_inst_data   <= '0;
            o_fetch_fault <= 1'b0;
        end else if (i_inst_rd_enable != 4'b0000) begin
            if (state == LOAD) begin
                o_inst_data   <= NOP_INST;
                o_fetch_fault <= 1'b0;
            end else if (fetch_ok) begin
                o_inst_data   <= mem[rd_word] & lane_mask;
                o_fetch_fault <= 1'b0;
            end else begin
                o_inst_data   <= '0;
                o_fetch_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_memory;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int unsigned CMAX  = 2047;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_inst_rd_enable = '0;
    logic [31:0] i_inst_addr = '0;
    logic [31:0] o_inst_data;
    logic        o_fetch_fault;
    logic        o_busy;
    logic        i_load_start = 1'b0;
    logic [31:0] i_load_addr = '0;
    logic        i_load_valid = 1'b0;
    logic [31:0] i_load_data = '0;
    logic        i_load_last = 1'b0;
    logic        o_load_ready;
    logic [10:0] o_load_count;
    logic        o_load_overflow;

    instruction_memory #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .NOP_INST   (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_inst_rd_enable(i_inst_rd_enable),
        .i_inst_addr     (i_inst_addr),
        .o_inst_data     (o_inst_data),
        .o_fetch_fault   (o_fetch_fault),
        .o_busy          (o_busy),
        .i_load_start    (i_load_start),
        .i_load_addr     (i_load_addr),
        .i_load_valid    (i_load_valid),
        .i_load_data     (i_load_data),
        .i_load_last     (i_load_last),
        .o_load_ready    (o_load_ready),
        .o_load_count    (o_load_count),
        .o_load_overflow (o_load_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_loading = 1'b0;
    int unsigned m_ptr = 0;
    int unsigned m_count = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_fault = 1'b0;
    longint      f_off;
    longint      l_off;

    assign f_off = longint'(i_inst_addr) - longint'(BASE);
    assign l_off = longint'(i_load_addr) - longint'(BASE);

    function automatic logic [31:0] lanes(input logic [3:0] en);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = en[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading <= 1'b0;
            m_ptr     <= 0;
            m_count   <= 0;
            m_ovf     <= 1'b0;
            m_data    <= '0;
            m_fault   <= 1'b0;
        end else begin
            if (i_inst_rd_enable != 4'b0000) begin
                if (m_loading) begin
                    m_data  <= NOP;
                    m_fault <= 1'b0;
                end else if (i_inst_addr[1:0] != 2'b00 || f_off < 0 || f_off >= longint'(DEPTH) * 4) begin
                    m_data  <= '0;
                    m_fault <= 1'b1;
                end else begin
                    m_data  <= m_mem[int'(f_off / 4)] & lanes(i_inst_rd_enable);
                    m_fault <= 1'b0;
                end
            end
            if (!m_loading) begin
                if (i_load_start) begin
                    m_loading <= 1'b1;
                    m_ptr     <= int'(((l_off & 64'hFFFF_FFFF) / 4) % DEPTH);
                    m_count   <= 0;
                    m_ovf     <= 1'b0;
                end
            end else if (i_load_valid) begin
                m_mem[m_ptr] <= i_load_data;
                if (m_ptr == DEPTH - 1) m_ovf <= 1'b1;
                m_ptr <= (m_ptr + 1) % DEPTH;
                if (m_count < CMAX) m_count <= m_count + 1;
                if (i_load_last) m_loading <= 1'b0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check32("model_data",  o_inst_data, m_data);
        check32("model_fault", 32'(o_fetch_fault), 32'(m_fault));
        check32("model_busy",  32'(o_busy), 32'(m_loading));
        check32("model_ready", 32'(o_load_ready), 32'(m_loading));
        check32("model_count", 32'(o_load_count), m_count);
        check32("model_ovf",   32'(o_load_overflow), 32'(m_ovf));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [3:0] en);
        i_inst_addr      = addr;
        i_inst_rd_enable = en;
        tick();
        i_inst_rd_enable = 4'b0000;
    endtask

    task automatic load_session(input logic [31:0] addr, input logic [31:0] words[$], input bit gaps);
        i_load_start = 1'b1;
        i_load_addr  = addr;
        tick();
        i_load_start = 1'b0;
        foreach (words[i]) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                i_load_valid = 1'b0;
                tick();
            end
            i_load_valid = 1'b1;
            i_load_data  = words[i];
            i_load_last  = (i == words.size() - 1);
            tick();
        end
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] prog[$];

        // Reset values.
        tick(); tick();
        check32("rst_data",  o_inst_data, 32'h0);
        check32("rst_fault", 32'(o_fetch_fault), 32'h0);
        check32("rst_busy",  32'(o_busy), 32'h0);
        check32("rst_ready", 32'(o_load_ready), 32'h0);
        check32("rst_count", 32'(o_load_count), 32'h0);
        check32("rst_ovf",   32'(o_load_overflow), 32'h0);
        rst_n = 1'b1;
        tick();

        // Fill the whole array so every later fetch has a known value.
        q = {};
        for (int i = 0; i < int'(DEPTH); i++) q.push_back($urandom());
        load_session(BASE, q, 1'b1);
        check32("full_count", 32'(o_load_count), 32'd1024);
        check32("full_busy",  32'(o_busy), 32'h0);

        // Load then fetch.
        prog = {32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
        i_load_start = 1'b1;
        i_load_addr  = 32'h0;
        tick();
        i_load_start = 1'b0;
        check32("load_busy_rise",  32'(o_busy), 32'h1);
        check32("load_ready_rise", 32'(o_load_ready), 32'h1);
        foreach (prog[i]) begin
            i_load_valid = 1'b1;
            i_load_data  = prog[i];
            i_load_last  = (i == 3);
            tick();
        end
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
        check32("prog_count", 32'(o_load_count), 32'd4);
        check32("prog_busy",  32'(o_busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), 4'b1111);
            check32("prog_fetch", o_inst_data, prog[i]);
        end

        // Byte-lane masking.
        fetch(32'h4, 4'b0101);
        check32("lane_mask", o_inst_data, 32'h00A00013 & 32'h00FF00FF);

        // Stall hold.
        fetch(32'h4, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            i_inst_addr = 32'h8;
            tick();
            check32("stall_hold", o_inst_data, 32'h00A00113);
        end

        // Faults.
        fetch(32'h2, 4'b1111);
        check32("misalign_data",  o_inst_data, 32'h0);
        check32("misalign_fault", 32'(o_fetch_fault), 32'h1);
        fetch(32'h1000, 4'b1111);
        check32("range_data",  o_inst_data, 32'h0);
        check32("range_fault", 32'(o_fetch_fault), 32'h1);
        fetch(32'h0, 4'b1111);
        check32("recover_fault", 32'(o_fetch_fault), 32'h0);
        check32("recover_data",  o_inst_data, 32'h00500093);

        // Fetch across the RUN/LOAD boundaries.
        i_load_start = 1'b1;
        i_load_addr  = 32'h10;
        i_inst_addr  = 32'h8;
        i_inst_rd_enable = 4'b1111;
        tick();
        i_load_start = 1'b0;
        check32("start_edge_fetch", o_inst_data, 32'h002081B3);
        tick();
        check32("load_fetch_nop",   o_inst_data, NOP);
        check32("load_fetch_fault", 32'(o_fetch_fault), 32'h0);
        check32("load_fetch_busy",  32'(o_busy), 32'h1);
        i_load_start = 1'b1;
        i_load_addr  = 32'h100;
        i_inst_addr  = 32'hC;
        i_load_valid = 1'b1;
        i_load_data  = 32'hCAFE_0001;
        i_load_last  = 1'b1;
        tick();
        i_load_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_last  = 1'b0;
        check32("last_edge_fetch", o_inst_data, NOP);
        fetch(32'h10, 4'b1111);
        check32("after_load_fetch", o_inst_data, 32'hCAFE_0001);

        // Wrap and overflow.
        load_session(32'hFFC, '{32'h1111_AAAA, 32'h2222_BBBB}, 1'b0);
        check32("wrap_count", 32'(o_load_count), 32'd2);
        check32("wrap_ovf",   32'(o_load_overflow), 32'h1);
        fetch(32'hFFC, 4'b1111);
        check32("wrap_hi", o_inst_data, 32'h1111_AAAA);
        fetch(32'h0, 4'b1111);
        check32("wrap_lo", o_inst_data, 32'h2222_BBBB);

        // Reset mid-load.
        i_load_start = 1'b1;
        i_load_addr  = 32'h20;
        tick();
        i_load_start = 1'b0;
        i_load_valid = 1'b1;
        i_load_data  = 32'h3333_0020;
        tick();
        i_load_data  = 32'h4444_0024;
        tick();
        i_load_valid = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        check32("mid_rst_count", 32'(o_load_count), 32'h0);
        check32("mid_rst_ready", 32'(o_load_ready), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        check32("post_rst_busy", 32'(o_busy), 32'h0);
        fetch(32'h20, 4'b1111);
        check32("kept_word0", o_inst_data, 32'h3333_0020);
        fetch(32'h24, 4'b1111);
        check32("kept_word1", o_inst_data, 32'h4444_0024);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            i_load_start = ($urandom_range(0, 29) == 0);
            i_load_addr  = 32'($urandom_range(0, DEPTH - 1)) * 4;
            i_load_valid = m_loading && ($urandom_range(0, 1) == 1);
            i_load_data  = $urandom();
            i_load_last  = ($urandom_range(0, 5) == 0);
            i_inst_rd_enable = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0) i_inst_addr = $urandom();
            else                           i_inst_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
            tick();
        end
        i_load_start = 1'b0;
        i_load_valid = 1'b0;
        i_inst_rd_enable = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Word-organised synchronous instruction memory that serves as the responder to the Instruction Fetch stage's read port. It returns a 32-bit instruction one cycle after each enabled fetch request. It holds its output while fetch is stalled and flags misaligned or out-of-range fetches. A streaming load port lets a boot controller or testbench write a program while the core is held off.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- NOP_INST, 32'h0000_0013: instruction returned while a load session is active.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_inst_rd_enable  in  4  byte-lane read enables from fetch; 4'b0000 = stall/no request.
- i_inst_addr  in  32  fetch byte address.
- o_inst_data  out  32  fetched instruction, registered.
- o_fetch_fault  out  1  registered; high with the data word when that request faulted.
- o_busy  out  1  high while a load session is active.
- i_load_start  in  1  single-cycle pulse; opens a load session at i_load_addr.
- i_load_addr  in  32  byte address of the first word to load; sampled with i_load_start.
- i_load_valid  in  1  load word valid.
- i_load_data  in  32  load word.
- i_load_last  in  1  marks the final word of the session; qualified by i_load_valid.
- o_load_ready  out  1  memory accepts a load word this cycle.
- o_load_count  out  clog2(DEPTH_WORDS)+1  words accepted in the current or last session.
- o_load_overflow  out  1  sticky; write pointer wrapped during the session.

## Operation
- Two-state FSM: RUN and LOAD. Reset enters RUN.
- **RUN to LOAD:** on i_load_start.
  - Write pointer = (i_load_addr - BASE_ADDR)[clog2(DEPTH_WORDS)+1:2].
  - o_load_count and o_load_overflow clear.
- **i_load_start while in LOAD:** ignored.
- **LOAD behaviour:**
  - o_load_ready=1 and o_busy=1.
  - Each cycle with i_load_valid && o_load_ready writes i_load_data to the pointer and increments both the pointer and o_load_count.
  - The pointer wraps from DEPTH_WORDS-1 to 0; a wrap sets o_load_overflow.
  - o_load_count saturates at its maximum.
- **LOAD to RUN:** on an accepted word with i_load_last=1. That word is written.
  - i_load_last without i_load_valid has no effect.
- **Fetch, RUN:** when i_inst_rd_enable != 0, the request is evaluated:
  - Misaligned (addr[1:0] != 0) or outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS): o_inst_data=0, o_fetch_fault=1.
  - Otherwise o_inst_data = mem[word], with lanes whose enable bit is 0 forced to 0x00; o_fetch_fault=0.
- **Fetch, LOAD:** any enabled request returns NOP_INST with o_fetch_fault=0.
- **Fetch, i_inst_rd_enable==0:** o_inst_data and o_fetch_fault hold their previous values. Fetch's stall depends on this.
- The array has no reset; contents survive rst_n.

## Timing
- Fetch latency is 1 cycle: a request sampled at edge N drives data from edge N+1.
- Load writes take effect at the accepting edge. A fetch of that word issued on the cycle after LOAD exits returns the new value.
- **RUN/LOAD boundary for fetch:**
  - A fetch sampled on the same edge as i_load_start returns memory data, since the FSM is still in RUN.
  - A fetch on the edge that accepts the last word returns NOP_INST.
- **Reset values:** o_inst_data=0, o_fetch_fault=0, o_busy=0, o_load_ready=0, o_load_count=0, o_load_overflow=0.
- **Reset mid-load:** the session aborts and the FSM returns to RUN. Already-written words remain; the count and overflow flag clear.
- o_busy and o_load_ready are registered FSM decodes; both rise the cycle after i_load_start.

## Test plan
- **Load then fetch:** load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x00000013 at 0x0 with last on the 4th, then fetch 0x0, 0x4, 0x8, 0xC with enable 4'b1111 -> the same words in order, each 1 cycle after its request; o_load_count=4, o_busy low after the last word.
- **Stall hold:** fetch 0x4, then 3 cycles with enable 0 -> o_inst_data stays 0x00A00113 throughout.
- **Faults:** fetch 0x2 -> data 0, fault 1. Fetch 0x1000 with DEPTH_WORDS=1024 -> data 0, fault 1. A following fetch of 0x0 -> fault 0.
- **Wrap/overflow:** start at 0xFFC with DEPTH_WORDS=1024 and load 2 words -> mem[1023] and mem[0] written, o_load_overflow=1, o_load_count=2.
- **Fetch during load:** fetch 0x8 while in LOAD -> 0x00000013, fault 0, o_busy=1.
- **Reset mid-load:** pulse rst_n low after 2 of 4 load words -> FSM in RUN, count 0, o_load_ready 0, and the 2 written words readable.
